// File: rtl/decoder_3to8_pipe.sv
// Registered binary-to-one-hot decoder behind a two-entry valid/ready skid buffer.
// The output register and the skid register carry the one-hot word, the echoed code and the "none" flag.
module decoder_3to8_pipe #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_code,
    input  logic                  in_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [(2**WIDTH)-1:0] out_onehot,
    output logic [WIDTH-1:0]      out_code,
    output logic                  out_none,
    output logic [CNT_W-1:0]      dec_count
);
    localparam int N = 2**WIDTH;

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    typedef struct packed {
        logic [N-1:0]     onehot;
        logic [WIDTH-1:0] code;
        logic             none;
    } item_t;

    logic [1:0] state, state_nx;
    item_t      or_q, sk_q, new_item;
    logic       acc, take;

    assign acc  = in_valid & in_ready;
    assign take = out_valid & out_ready;

    // Decoded word is only captured on acc, so junk on idle inputs never reaches a register.
    always_comb begin
        new_item.onehot = '0;
        for (int i = 0; i < N; i++)
            if (in_en && in_code == WIDTH'(i)) new_item.onehot[i] = 1'b1;
        new_item.code = in_code;
        new_item.none = ~in_en;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_EMPTY: if (acc) state_nx = S_BUSY;
            S_BUSY: begin
                if (acc && !take)      state_nx = S_FULL;
                else if (!acc && take) state_nx = S_EMPTY;
            end
            S_FULL:  if (take) state_nx = S_BUSY;
            default: state_nx = S_EMPTY;
        endcase
    end

    // in_ready/out_valid are registered copies of the next state, keeping out_ready off any comb path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            or_q      <= '0;
            sk_q      <= '0;
            dec_count <= '0;
        end else begin
            state     <= state_nx;
            in_ready  <= (state_nx != S_FULL);
            out_valid <= (state_nx != S_EMPTY);
            case (state)
                S_EMPTY: if (acc) or_q <= new_item;
                S_BUSY: begin
                    if (acc && take) or_q <= new_item;
                    else if (acc)    sk_q <= new_item;
                end
                S_FULL:  if (take) or_q <= sk_q;
                default: ;
            endcase
            if (acc && in_en && dec_count != {CNT_W{1'b1}})
                dec_count <= dec_count + CNT_W'(1);
        end
    end

    assign out_onehot = or_q.onehot;
    assign out_code   = or_q.code;
    assign out_none   = or_q.none;

endmodule
